pwm_measure: RTL and testbench

PWM_MEASURE -- requirements
Module: pwm_measure

---
 rtl/pwm_measure.sv | 146 ++++++++++++++
 tb/tb_pwm_measure.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_measure.sv
// Measures the high time and period of an asynchronous PWM waveform in clk cycles.
// Results update on each rising edge; a sticky timeout reports a stuck input.
module pwm_measure #(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         pwm_in,
    output logic [W-1:0] high_cnt,
    output logic [W-1:0] period_cnt,
    output logic         valid,
    output logic         timeout,
    output logic         level
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    // Edge events are pipelined so that valid lands SYNC_STAGES+2 cycles after the sampling edge.
    localparam int EDGE_LAT = 2;

    localparam logic [W-1:0] CNT_ONE   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_MAX   = {W{1'b1}};
    localparam logic [W-1:0] ARM_LIMIT = {{(W-1){1'b1}}, 1'b0};

    logic [SYNC_STAGES-1:0]   sync_reg;
    logic                     s;
    logic                     s_d_reg;
    logic                     rise;
    logic                     fall;
    logic [EDGE_LAT-1:0][2:0] edge_pipe_reg;
    logic                     ev_level;
    logic                     ev_rise;
    logic                     ev_fall;
    logic [1:0]               state_reg;
    logic [W-1:0]             hcnt_reg;
    logic [W-1:0]             pcnt_reg;

    assign s    = sync_reg[SYNC_STAGES-1];
    assign rise = s & ~s_d_reg;
    assign fall = ~s & s_d_reg;

    assign ev_level = edge_pipe_reg[EDGE_LAT-1][2];
    assign ev_rise  = edge_pipe_reg[EDGE_LAT-1][1];
    assign ev_fall  = edge_pipe_reg[EDGE_LAT-1][0];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg      <= '0;
            s_d_reg       <= 1'b0;
            edge_pipe_reg <= '0;
        end else begin
            sync_reg         <= {sync_reg[SYNC_STAGES-2:0], pwm_in};
            s_d_reg          <= s;
            edge_pipe_reg[0] <= {s, rise, fall};
            for (int i = 1; i < EDGE_LAT; i++) begin
                edge_pipe_reg[i] <= edge_pipe_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            hcnt_reg   <= '0;
            pcnt_reg   <= '0;
            high_cnt   <= '0;
            period_cnt <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
            level      <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!en) begin
                state_reg <= ST_IDLE;
                hcnt_reg  <= '0;
                pcnt_reg  <= '0;
                timeout   <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        state_reg <= ST_ARM;
                        hcnt_reg  <= '0;
                        pcnt_reg  <= '0;
                    end
                    ST_ARM: begin
                        // In ARM pcnt only measures how long we have waited for a rise.
                        if (ev_rise) begin
                            state_reg <= ST_HIGH;
                            hcnt_reg  <= CNT_ONE;
                            pcnt_reg  <= CNT_ONE;
                        end else if (pcnt_reg == ARM_LIMIT) begin
                            timeout  <= 1'b1;
                            level    <= ev_level;
                            pcnt_reg <= '0;
                        end else begin
                            pcnt_reg <= pcnt_reg + CNT_ONE;
                        end
                    end
                    ST_HIGH: begin
                        if (pcnt_reg == CNT_MAX) begin
                            state_reg <= ST_ARM;
                            timeout   <= 1'b1;
                            level     <= ev_level;
                            hcnt_reg  <= '0;
                            pcnt_reg  <= '0;
                        end else begin
                            pcnt_reg <= pcnt_reg + CNT_ONE;
                            if (ev_fall) begin
                                state_reg <= ST_LOW;
                            end else begin
                                hcnt_reg <= hcnt_reg + CNT_ONE;
                            end
                        end
                    end
                    ST_LOW: begin
                        if (ev_rise) begin
                            high_cnt   <= hcnt_reg;
                            period_cnt <= pcnt_reg;
                            valid      <= 1'b1;
                            state_reg  <= ST_HIGH;
                            hcnt_reg   <= CNT_ONE;
                            pcnt_reg   <= CNT_ONE;
                        end else if (pcnt_reg == CNT_MAX) begin
                            state_reg <= ST_ARM;
                            timeout   <= 1'b1;
                            level     <= ev_level;
                            hcnt_reg  <= '0;
                            pcnt_reg  <= '0;
                        end else begin
                            pcnt_reg <= pcnt_reg + CNT_ONE;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_measure.sv
// Directed bench for pwm_measure: completed periods are queued as expected results
// (with the cycle they are due) and checked whenever valid pulses.
module tb_pwm_measure;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         pwm_in;
    logic [W-1:0] high_cnt;
    logic [W-1:0] period_cnt;
    logic         valid;
    logic         timeout;
    logic         level;

    typedef struct {
        int     h;
        int     p;
        longint due;
    } exp_t;

    exp_t   sb_q[$];
    longint cyc = 0;
    int     errors = 0;
    int     checks = 0;
    int     pend_h = 0;
    int     pend_p = 0;
    bit     pend_ok = 1'b0;

    pwm_measure #(.W(W), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pwm_in     (pwm_in),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .valid      (valid),
        .timeout    (timeout),
        .level      (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A 0->1 transition completes the pending period, whose result is due LAT cycles later.
    task automatic drive_high(input int n);
        if (pwm_in == 1'b0) begin
            if (pend_ok) begin
                sb_q.push_back('{pend_h, pend_p, cyc + LAT});
            end
            pend_ok = 1'b0;
        end
        pwm_in = 1'b1;
        repeat (n) tick();
    endtask

    task automatic drive_low(input int n);
        pwm_in = 1'b0;
        repeat (n) tick();
    endtask

    task automatic run_period(input int d, input int t);
        drive_high(d);
        drive_low(t - d);
        pend_h  = d;
        pend_p  = t;
        pend_ok = 1'b1;
    endtask

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_valid_sb_depth", sb_q.size(), 1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("high_cnt", high_cnt, e.h);
                chk("period_cnt", period_cnt, e.p);
                chk("valid_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        pwm_in = 1'b0;
        repeat (3) tick();
        chk("reset_valid", valid, 0);
        chk("reset_timeout", timeout, 0);
        chk("reset_level", level, 0);
        chk("reset_high_cnt", high_cnt, 0);
        chk("reset_period_cnt", period_cnt, 0);

        // Steady D=3/T=10, then a duty change to D=7 at a period boundary
        rst = 1'b0;
        tick();
        en = 1'b1;
        drive_low(4);
        repeat (5) run_period(3, 10);
        repeat (3) run_period(7, 10);
        drive_high(6);

        // en dropped mid-period: no valid, timeout clear, results held
        en = 1'b0;
        pend_ok = 1'b0;
        drive_high(2);
        drive_low(3);
        chk("en_drop_timeout", timeout, 0);
        chk("en_drop_high_cnt", high_cnt, 7);
        chk("en_drop_period_cnt", period_cnt, 10);
        en = 1'b1;
        drive_low(4);
        repeat (3) run_period(3, 10);

        // Minimum pulse
        repeat (6) run_period(1, 2);
        drive_high(1);
        drive_low(8);

        // Input stuck low: timeout exactly 255 cycles after arming
        en = 1'b0;
        pend_ok = 1'b0;
        tick();
        tick();
        en = 1'b1;
        repeat (255) tick();
        chk("stuck_low_timeout_early", timeout, 0);
        tick();
        chk("stuck_low_timeout", timeout, 1);
        chk("stuck_low_level", level, 0);
        chk("stuck_low_high_cnt", high_cnt, 1);
        chk("stuck_low_period_cnt", period_cnt, 2);

        // Input stuck high: rise resumes measurement, then times out in HIGH
        drive_high(300);
        chk("stuck_high_timeout", timeout, 1);
        chk("stuck_high_level", level, 1);
        chk("stuck_high_high_cnt", high_cnt, 1);
        chk("stuck_high_period_cnt", period_cnt, 2);
        drive_low(6);
        repeat (3) run_period(5, 20);
        drive_high(6);
        chk("resume_timeout_sticky", timeout, 1);

        // Reset pulse during HIGH
        rst    = 1'b1;
        pwm_in = 1'b0;
        tick();
        rst     = 1'b0;
        pend_ok = 1'b0;
        chk("midrst_valid", valid, 0);
        chk("midrst_timeout", timeout, 0);
        chk("midrst_level", level, 0);
        chk("midrst_high_cnt", high_cnt, 0);
        chk("midrst_period_cnt", period_cnt, 0);
        drive_low(5);
        repeat (3) run_period(4, 9);
        drive_high(3);
        drive_low(10);

        chk("results_outstanding", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
